// File: rtl/vga_pkg.sv
// vga_pkg: shared counter width, 640x480 timing constants and receiver lock states
package vga_pkg;
  localparam int CW = 13;
  localparam int H_TOTAL = 800;
  localparam int H_SYNC = 96;
  localparam int V_TOTAL = 525;
  localparam int V_SYNC = 2;
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: registers a sync pin, normalises it to active-high and flags leading/trailing edges
module sync_edge #(
  parameter bit POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise,
  output logic fall
);
  logic s, p;
  always_ff @(posedge clk) begin
    if (rst) {s, p} <= '0;
    else {s, p} <= {pin ~^ POL, s};
  end
  assign rise = s & ~p;
  assign fall = ~s & p;
endmodule

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel position from HS/VS, measures sync timing and flags stable lock
module vga_sync_rx #(
  parameter int CW = vga_pkg::CW,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          CLK25M,
  input  logic          RST,
  input  logic          VGA_HS,
  input  logic          VGA_VS,
  output logic [CW-1:0] RxHCnt,
  output logic [CW-1:0] RxVCnt,
  output logic [CW-1:0] LineLen,
  output logic [CW-1:0] HsWidth,
  output logic [CW-1:0] FrameLines,
  output logic [CW-1:0] VsWidth,
  output logic          Locked,
  output logic          Err
);
  import vga_pkg::*;
  localparam logic [7:0] LOCK_M = 8'(LOCK_FRAMES - 1);
  logic hs_rise, hs_fall, vs_rise, vs_fall;
  logic sat, line_ne, tup_ne, frame_ok, line_bad, have_ref;
  logic [CW-1:0] hcnt, vcnt, len_n, hsw_n, fl_n, vsw_n;
  logic [4*CW-1:0] tup_n, tup_q;
  logic [7:0] match;
  state_t state;

  sync_edge #(.POL(HS_POL)) u_hs (.clk(CLK25M), .rst(RST), .pin(VGA_HS), .rise(hs_rise), .fall(hs_fall));
  sync_edge #(.POL(VS_POL)) u_vs (.clk(CLK25M), .rst(RST), .pin(VGA_VS), .rise(vs_rise), .fall(vs_fall));

  always_comb begin
    len_n = hs_rise ? hcnt + 1'b1 : LineLen;
    hsw_n = hs_fall ? hcnt + 1'b1 : HsWidth;
    fl_n = vs_rise ? vcnt + 1'b1 : FrameLines;
    vsw_n = vs_fall ? vcnt : VsWidth;
    tup_n = {len_n, hsw_n, fl_n, vsw_n};
    sat = &hcnt;
    line_ne = hs_rise && (len_n != LineLen);
    tup_ne = tup_n != tup_q;
    frame_ok = !tup_ne && !line_bad && !line_ne;
  end

  always_ff @(posedge CLK25M) begin
    if (RST) begin
      {hcnt, vcnt, RxHCnt, RxVCnt, LineLen, HsWidth, FrameLines, VsWidth, tup_q} <= '0;
      {match, line_bad, have_ref, Locked, Err} <= '0;
      state <= SEARCH;
    end else begin
      hcnt <= hs_rise ? '0 : sat ? hcnt : hcnt + 1'b1;
      vcnt <= vs_rise ? '0 : hs_rise ? vcnt + 1'b1 : vcnt;
      {RxHCnt, RxVCnt} <= {hcnt, vcnt};
      {LineLen, HsWidth, FrameLines, VsWidth} <= tup_n;
      Err <= 1'b0;
      if (line_ne) line_bad <= 1'b1;
      if (sat) begin
        state <= SEARCH;
        Locked <= 1'b0;
        Err <= state == LOCKED;
        match <= '0;
      end else if (state == SEARCH) begin
        if (vs_rise) begin
          state <= MEASURE;
          {match, line_bad, have_ref} <= '0;
        end
      end else if (state == MEASURE) begin
        if (vs_rise) begin
          tup_q <= tup_n;
          line_bad <= 1'b0;
          have_ref <= 1'b1;
          match <= (have_ref && frame_ok) ? match + 8'd1 : '0;
          if (have_ref && frame_ok && match + 8'd1 >= LOCK_M) begin
            state <= LOCKED;
            Locked <= 1'b1;
          end
        end
      end else if (line_ne || (vs_rise && tup_ne)) begin
        state <= SEARCH;
        Locked <= 1'b0;
        Err <= 1'b1;
      end else if (vs_rise) begin
        tup_q <= tup_n;
        line_bad <= 1'b0;
      end
    end
  end
endmodule
